// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: command sequencer between an SPI slave byte interface and a
// 4-entry byte register file.
//
// Each chip-select frame works like this:
//   - The first byte is a command: bit7 = write, bits[6:2] must be zero,
//     bits[1:0] = start address.
//   - The data bytes that follow stream into the register file (write), or
//     out of it (read). The address auto-increments and wraps 3->0.
//
// Ports
//   i_clk       system clock
//   i_sys_rst   synchronous active-low reset
//   i_cs        raw SPI chip-select pin (active low, asynchronous)
//   i_rx_byte   received byte, valid with i_rx_valid
//   i_rx_valid  one-cycle pulse per received byte
//   o_tx_byte   byte for the SPI slave to shift out next
//   o_tx_load   one-cycle strobe telling the slave to latch o_tx_byte
//   o_led       reg0[3:0]
//   o_err_cnt   saturating count of malformed command bytes
//   o_busy      high while a frame is active
module spi_cmd_ctrl #(
    parameter logic [7:0] ID_VAL  = 8'hA5,
    parameter logic [7:0] ERR_SAT = 8'hFF
) (
    input  logic       i_clk,
    input  logic       i_sys_rst,
    input  logic       i_cs,
    input  logic [7:0] i_rx_byte,
    input  logic       i_rx_valid,
    output logic [7:0] o_tx_byte,
    output logic       o_tx_load,
    output logic [3:0] o_led,
    output logic [7:0] o_err_cnt,
    output logic       o_busy
);

    typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, DISCARD} state_t;

    state_t          state_q, state_d;
    logic [1:0]      addr_q, addr_d;
    logic [2:0][7:0] regs_q, regs_d;
    logic [7:0]      err_q, err_d;
    logic [7:0]      txb_q, txb_d;
    logic            txl_q, txl_d;

    // The CS synchronizer and edge-detect flops reset to 0 ("selected").
    // If i_cs is still low when reset releases, no falling edge is seen,
    // so a frame that was cut by reset is not re-entered. If i_cs is high,
    // a rising edge is seen while in IDLE, which does nothing.
    logic cs_meta_q, cs_s_q, cs_prev_q;
    logic frame_start, frame_end;

    assign frame_start = cs_prev_q & ~cs_s_q;
    assign frame_end   = ~cs_prev_q & cs_s_q;

    // Read mux: reg3 is the fixed ID value.
    function automatic logic [7:0] rd_reg(input logic [2:0][7:0] r,
                                          input logic [1:0] a);
        return (a == 2'd3) ? ID_VAL : r[a];
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_sys_rst) begin
            cs_meta_q <= 1'b0;
            cs_s_q    <= 1'b0;
            cs_prev_q <= 1'b0;
            state_q   <= IDLE;
            addr_q    <= '0;
            regs_q    <= '0;
            err_q     <= '0;
            txb_q     <= '0;
            txl_q     <= 1'b0;
        end else begin
            cs_meta_q <= i_cs;
            cs_s_q    <= cs_meta_q;
            cs_prev_q <= cs_s_q;
            state_q   <= state_d;
            addr_q    <= addr_d;
            regs_q    <= regs_d;
            err_q     <= err_d;
            txb_q     <= txb_d;
            txl_q     <= txl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        regs_d  = regs_q;
        err_d   = err_q;
        txb_d   = txb_q;
        txl_d   = 1'b0;

        // Frame end has priority over everything, including a byte that
        // arrives in the same cycle; that byte is dropped.
        if (frame_end) begin
            state_d = IDLE;
            addr_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        state_d = CMD;
                        txb_d   = 8'h00;
                        txl_d   = 1'b1;
                    end
                end
                CMD: begin
                    if (i_rx_valid) begin
                        if (|i_rx_byte[6:2]) begin
                            if (err_q != ERR_SAT) err_d = err_q + 8'd1;
                            state_d = DISCARD;
                        end else if (i_rx_byte[7]) begin
                            addr_d  = i_rx_byte[1:0];
                            state_d = WRITE;
                        end else begin
                            txb_d   = rd_reg(regs_q, i_rx_byte[1:0]);
                            txl_d   = 1'b1;
                            addr_d  = i_rx_byte[1:0] + 2'd1;
                            state_d = READ;
                        end
                    end
                end
                WRITE: begin
                    if (i_rx_valid) begin
                        // Writes to the ID slot are dropped.
                        if (addr_q != 2'd3) regs_d[addr_q] = i_rx_byte;
                        addr_d = addr_q + 2'd1;
                    end
                end
                READ: begin
                    // The received byte is a dummy; it only paces the read.
                    if (i_rx_valid) begin
                        txb_d  = rd_reg(regs_q, addr_q);
                        txl_d  = 1'b1;
                        addr_d = addr_q + 2'd1;
                    end
                end
                DISCARD: ;
                default: state_d = IDLE;
            endcase
        end
    end

    assign o_tx_byte = txb_q;
    assign o_tx_load = txl_q;
    assign o_led     = regs_q[0][3:0];
    assign o_err_cnt = err_q;
    assign o_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
module tb_spi_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic [3:0] led;
    logic [7:0] err_cnt;
    logic       busy;

    int vec  = 0;
    int miss = 0;

    logic [7:0] sb_q[$];     // expected o_tx_byte values, in load order
    logic [7:0] mdl[4];      // reference register file

    spi_cmd_ctrl dut (
        .i_clk      (clk),
        .i_sys_rst  (rst_n),
        .i_cs       (cs),
        .i_rx_byte  (rx_byte),
        .i_rx_valid (rx_valid),
        .o_tx_byte  (tx_byte),
        .o_tx_load  (tx_load),
        .o_led      (led),
        .o_err_cnt  (err_cnt),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every load must match the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n && tx_load === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_load", {24'd0, tx_byte}, 32'hFFFF_FFFF);
            end else begin
                chk("tx_byte", {24'd0, tx_byte}, {24'd0, sb_q.pop_front()});
            end
        end
    end

    // All tasks start and end at a negedge.
    task automatic send_byte(input logic [7:0] b, input logic exp_load, input logic [7:0] exp_val);
        rx_byte  = b;
        rx_valid = 1'b1;
        if (exp_load) sb_q.push_back(exp_val);
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
        chk("load_timing", {31'd0, tx_load}, {31'd0, exp_load});
    endtask

    task automatic cs_low();
        cs = 1'b0;
        sb_q.push_back(8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("busy_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic cs_high();
        cs = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("busy_end", {31'd0, busy}, 32'd0);
    endtask

    task automatic read_all();
        cs_low();
        send_byte(8'h00, 1'b1, mdl[0]);
        for (int i = 1; i < 4; i++) send_byte(8'h00, 1'b1, mdl[i]);
        cs_high();
    endtask

    initial begin
        rst_n = 1'b0; cs = 1'b1; rx_byte = '0; rx_valid = 1'b0;
        mdl[0] = 8'h00; mdl[1] = 8'h00; mdl[2] = 8'h00; mdl[3] = 8'hA5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        chk("rst_tx_load", {31'd0, tx_load}, 32'd0);
        chk("rst_busy",    {31'd0, busy},    32'd0);
        chk("rst_led",     {28'd0, led},     32'd0);
        chk("rst_err",     {24'd0, err_cnt}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Write frame, back-to-back data bytes
        cs_low();
        send_byte(8'h80, 1'b0, 8'h00);
        send_byte(8'h0F, 1'b0, 8'h00);
        send_byte(8'h12, 1'b0, 8'h00);
        send_byte(8'h34, 1'b0, 8'h00);
        cs_high();
        mdl[0] = 8'h0F; mdl[1] = 8'h12; mdl[2] = 8'h34;
        chk("wr_led", {28'd0, led},     32'h0000_000F);
        chk("wr_err", {24'd0, err_cnt}, 32'd0);

        // Read with wrap: 34, A5, 0F, 12
        cs_low();
        send_byte(8'h02, 1'b1, 8'h34);
        send_byte(8'h00, 1'b1, 8'hA5);
        send_byte(8'h00, 1'b1, 8'h0F);
        send_byte(8'h00, 1'b1, 8'h12);
        cs_high();

        // Malformed frames, saturating error counter
        for (int f = 0; f < 300; f++) begin
            cs_low();
            send_byte(8'h44, 1'b0, 8'h00);
            send_byte(8'hFF, 1'b0, 8'h00);
            cs_high();
            if (f == 0) chk("err_first", {24'd0, err_cnt}, 32'd1);
        end
        chk("err_sat", {24'd0, err_cnt}, 32'h0000_00FF);
        read_all();

        // Frame end in CMD with no byte: not an error
        cs_low();
        cs_high();
        chk("err_empty_frame", {24'd0, err_cnt}, 32'h0000_00FF);

        // Write to the ID slot is ignored
        cs_low();
        send_byte(8'h83, 1'b0, 8'h00);
        send_byte(8'h00, 1'b0, 8'h00);
        cs_high();
        read_all();

        // Collision: data byte lands in the same cycle as the CS rising edge
        cs_low();
        send_byte(8'h80, 1'b0, 8'h00);
        cs = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rx_byte = 8'h77; rx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
        chk("coll_busy", {31'd0, busy},    32'd0);
        chk("coll_load", {31'd0, tx_load}, 32'd0);
        chk("coll_led",  {28'd0, led},     32'h0000_000F);
        repeat (2) @(negedge clk);
        read_all();

        // Reset mid-frame with CS held low
        cs_low();
        send_byte(8'h81, 1'b0, 8'h00);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mdl[0] = 8'h00; mdl[1] = 8'h00; mdl[2] = 8'h00;
        chk("mrst_busy", {31'd0, busy},    32'd0);
        chk("mrst_led",  {28'd0, led},     32'd0);
        chk("mrst_err",  {24'd0, err_cnt}, 32'd0);
        chk("mrst_txb",  {24'd0, tx_byte}, 32'd0);
        repeat (4) @(negedge clk);
        send_byte(8'h55, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        chk("mrst_idle", {31'd0, busy}, 32'd0);
        chk("mrst_led2", {28'd0, led},  32'd0);
        cs_high();
        read_all();

        // Normal write after recovery
        cs_low();
        send_byte(8'h81, 1'b0, 8'h00);
        send_byte(8'h5A, 1'b0, 8'h00);
        cs_high();
        mdl[1] = 8'h5A;
        read_all();

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
